// File: rtl/spi_pkg.sv
// Shared types and helpers for the SPI master family: FSM states, mode
// encodings ({cpol, cpha}) and a configuration clamp.
package spi_pkg;

  typedef enum logic [1:0] {IDLE, FRONT, SHIFT, BACK} state_t;

  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;

  // Zero maps to zero_val, anything above max_val saturates to max_val.
  function automatic int unsigned clamp_cfg(input int unsigned v,
                                            input int unsigned zero_val,
                                            input int unsigned max_val);
    if (v == 0) return zero_val;
    else if (v > max_val) return max_val;
    else return v;
  endfunction

endpackage

// File: rtl/spi_clk_div.sv
// H-cycle divider: counts 0..half-1 while enabled and flags the terminal
// count, wrapping to 0 on that cycle; load holds the count at 0.
module spi_clk_div #(
  parameter int unsigned DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             en,
  input  logic [DIV_W-1:0] half,
  output logic             tc
);

  logic [DIV_W-1:0] cnt;

  assign tc = en && (cnt == half - DIV_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    cnt <= '0;
    else if (load) cnt <= '0;
    else if (en)   cnt <= tc ? '0 : cnt + DIV_W'(1);
  end

endmodule

// File: rtl/spi_mstr_gen.sv
// Parametrised SPI master: runtime frame length, all four CPOL/CPHA modes,
// MSB/LSB-first and programmable SCLK half-period. Define SPI_MSTR_MISO_EN
// to add full-duplex receive (MISO in, rx_data out).
module spi_mstr_gen
  import spi_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DIV_W  = 8,
  parameter int unsigned LEN_W  = $clog2(DATA_W + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wrt,
  input  logic [DATA_W-1:0] data_out,
  input  logic [LEN_W-1:0]  len,
  input  logic              cpol,
  input  logic              cpha,
  input  logic              lsb_first,
  input  logic [DIV_W-1:0]  half_div,
  output logic              SS_n,
  output logic              SCLK,
  output logic              MOSI,
  output logic              busy,
`ifdef SPI_MSTR_MISO_EN
  input  logic              MISO,
  output logic [DATA_W-1:0] rx_data,
`endif
  output logic              done
);

  localparam int unsigned HMAX = (2 ** DIV_W) - 1;

  state_t            state;
  logic [LEN_W-1:0]  l_q;
  logic [DIV_W-1:0]  h_q;
  logic [1:0]        mode_q;
  logic              lsb_q;
  logic [DATA_W-1:0] shreg;
  logic [LEN_W:0]    edge_cnt;
  logic [LEN_W:0]    nxt_edge;
  logic [LEN_W:0]    last_edge;
  logic              tc;
  logic              leading;
  logic              do_present;
  logic              cur_bit;
  logic [DATA_W-1:0] shifted;
  logic              first_in;
  logic [DATA_W-1:0] shift_in;
  logic [LEN_W-1:0]  l_in;
  logic [DIV_W-1:0]  h_in;

  spi_clk_div #(.DIV_W(DIV_W)) u_div (
    .clk  (clk),
    .rst_n(rst_n),
    .load (state == IDLE),
    .en   (state != IDLE),
    .half (h_q),
    .tc   (tc)
  );

  assign nxt_edge  = edge_cnt + (LEN_W + 1)'(1);
  assign last_edge = {l_q, 1'b0};
  assign leading   = nxt_edge[0];
  assign l_in      = LEN_W'(clamp_cfg(32'(len), DATA_W, DATA_W));
  assign h_in      = DIV_W'(clamp_cfg(32'(half_div), 1, HMAX));

  always_comb begin
    cur_bit  = lsb_q ? shreg[0] : shreg[DATA_W-1];
    shifted  = lsb_q ? (shreg >> 1) : (shreg << 1);
    first_in = lsb_first ? data_out[0] : data_out[DATA_W-1];
    shift_in = lsb_first ? (data_out >> 1) : (data_out << 1);
    // cpha=0 pre-loads bit 0 at accept, so it advances on trailing edges
    // (never after the final one); cpha=1 advances on every leading edge.
    do_present = 1'b0;
    unique case (mode_q)
      MODE0, MODE2: do_present = !leading && (nxt_edge != last_edge);
      MODE1, MODE3: do_present = leading;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      SS_n     <= 1'b1;
      SCLK     <= 1'b0;
      MOSI     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      l_q      <= '0;
      h_q      <= '0;
      mode_q   <= MODE0;
      lsb_q    <= 1'b0;
      shreg    <= '0;
      edge_cnt <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          SCLK <= cpol;
          if (wrt) begin
            l_q      <= l_in;
            h_q      <= h_in;
            mode_q   <= {cpol, cpha};
            lsb_q    <= lsb_first;
            edge_cnt <= '0;
            SS_n     <= 1'b0;
            busy     <= 1'b1;
            state    <= FRONT;
            if (!cpha) begin
              MOSI  <= first_in;
              shreg <= shift_in;
            end else begin
              shreg <= data_out;
            end
          end
        end
        // FRONT's terminal count is edge 1, so it shares the edge logic.
        FRONT, SHIFT: begin
          if (tc) begin
            SCLK     <= leading ? ~mode_q[1] : mode_q[1];
            edge_cnt <= nxt_edge;
            state    <= (nxt_edge == last_edge) ? BACK : SHIFT;
            if (do_present) begin
              MOSI  <= cur_bit;
              shreg <= shifted;
            end
          end
        end
        BACK: begin
          if (tc) begin
            SS_n  <= 1'b1;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
      endcase
    end
  end

`ifdef SPI_MSTR_MISO_EN
  logic [DATA_W-1:0] rx_sh;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_sh   <= '0;
      rx_data <= '0;
    end else begin
      if (state == IDLE && wrt)
        rx_sh <= '0;
      else if ((state == FRONT || state == SHIFT) && tc && (leading ^ mode_q[0]))
        rx_sh <= lsb_q ? {MISO, rx_sh[DATA_W-1:1]} : {rx_sh[DATA_W-2:0], MISO};
      if (state == BACK && tc)
        rx_data <= rx_sh;
    end
  end
`endif

endmodule

// File: tb/tb_spi_mstr_gen.sv
// Directed self-checking bench for spi_mstr_gen; a negedge monitor captures
// bits on the sampling edges and times SS_n, the main sequence checks them.
module tb_spi_mstr_gen;
  import spi_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wrt;
  logic [15:0] data_out;
  logic [4:0]  len;
  logic        cpol;
  logic        cpha;
  logic        lsb_first;
  logic [7:0]  half_div;
  logic        SS_n;
  logic        SCLK;
  logic        MOSI;
  logic        busy;
  logic        done;
`ifdef SPI_MSTR_MISO_EN
  logic [15:0] rx_data;
`endif

  spi_mstr_gen #(.DATA_W(16), .DIV_W(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wrt      (wrt),
    .data_out (data_out),
    .len      (len),
    .cpol     (cpol),
    .cpha     (cpha),
    .lsb_first(lsb_first),
    .half_div (half_div),
    .SS_n     (SS_n),
    .SCLK     (SCLK),
    .MOSI     (MOSI),
    .busy     (busy),
`ifdef SPI_MSTR_MISO_EN
    .MISO     (MOSI),
    .rx_data  (rx_data),
`endif
    .done     (done)
  );

  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;
  int done_base = 0;
  int frames_base = 0;
  logic tb_cpol = 1'b0;
  logic tb_cpha = 1'b0;

  int          low_cnt = 0;
  int          nbits = 0;
  int          m_edges = 0;
  int          first_low = 0;
  int          done_cnt = 0;
  int          frames = 0;
  logic [31:0] cap = '0;
  logic        prev_ss = 1'b1;
  logic        prev_sclk = 1'b0;

  always @(negedge clk) begin
    if (prev_ss && !SS_n) begin
      low_cnt = 0; nbits = 0; m_edges = 0; first_low = 0; cap = '0;
      frames++;
    end
    if (!SS_n) low_cnt++;
    if (done) done_cnt++;
    if (!SS_n && SCLK !== prev_sclk) begin
      m_edges++;
      if (m_edges == 1) first_low = low_cnt;
      if ((SCLK !== tb_cpol) ^ tb_cpha) begin
        cap = {cap[30:0], MOSI};
        nbits++;
      end
    end
    prev_ss   = SS_n;
    prev_sclk = SCLK;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_done(input string tag, input int max_cyc);
    int n = 0;
    while (done !== 1'b1 && n < max_cyc) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_done_seen"}, 32'(done), 32'd1);
  endtask

  task automatic frame(input string tag, input logic cp, input logic ch, input logic lsb,
                       input logic [15:0] d, input logic [4:0] ln, input logic [7:0] hd);
    tb_cpol = cp; tb_cpha = ch;
    cpol = cp; cpha = ch; lsb_first = lsb; data_out = d; len = ln; half_div = hd;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk({tag, "_idle_sclk"}, 32'(SCLK), 32'(cp));
    done_base = done_cnt;
    wrt = 1'b1;
    @(posedge clk); #1;
    wrt = 1'b0;
    // scramble inputs after acceptance; the frame must use latched values
    data_out = ~d; len = 5'd3; half_div = 8'd7; lsb_first = ~lsb; cpha = ~ch;
    wait_done(tag, 10000);
    chk({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    @(negedge clk); #1;
  endtask

  task automatic check_frame(input string tag, input logic [31:0] bits, input int n,
                             input int low, input int h);
    chk({tag, "_bits"}, cap, bits);
    chk({tag, "_nbits"}, 32'(nbits), 32'(n));
    chk({tag, "_edges"}, 32'(m_edges), 32'(2 * n));
    chk({tag, "_ss_low"}, 32'(low_cnt), 32'(low));
    chk({tag, "_first_edge"}, 32'(first_low), 32'(h + 1));
    chk({tag, "_done_pulses"}, 32'(done_cnt - done_base), 32'd1);
  endtask

  initial begin
    logic [1:0] modes [4];
    int         k;
    logic       prev;
    modes[0] = MODE0; modes[1] = MODE1; modes[2] = MODE2; modes[3] = MODE3;

    rst_n = 1'b0; wrt = 1'b0; data_out = '0; len = '0;
    cpol = 1'b0; cpha = 1'b0; lsb_first = 1'b0; half_div = 8'd2;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {27'd0, SS_n, SCLK, MOSI, busy, done}, {27'd0, 5'b10000});
    rst_n = 1'b1;

    // byte 0x66 in every mode, H=2: L=8 -> 17*2 = 34 cycles low
    for (int m = 0; m < 4; m++) begin
      frame($sformatf("mode%0d", m), modes[m][1], modes[m][0], 1'b0, 16'h6600, 5'd8, 8'd2);
      check_frame($sformatf("mode%0d", m), 32'h66, 8, 34, 2);
    end

    // LSB-first, half_div=0 -> H=1; len=0 and len=16 both mean 16 bits
    frame("len0", 1'b0, 1'b0, 1'b1, 16'hA5C3, 5'd0, 8'd0);
    check_frame("len0", 32'hC3A5, 16, 33, 1);
    frame("len16", 1'b0, 1'b0, 1'b1, 16'hA5C3, 5'd16, 8'd0);
    check_frame("len16", 32'hC3A5, 16, 33, 1);
    frame("len20", 1'b1, 1'b1, 1'b1, 16'hA5C3, 5'd20, 8'd1);
    check_frame("len20", 32'hC3A5, 16, 33, 1);

    frame("len1", 1'b0, 1'b1, 1'b0, 16'h8000, 5'd1, 8'd3);
    check_frame("len1", 32'h1, 1, 9, 3);

    // longest legal frame: 16 bits, H=255 -> 33*255 cycles low
    frame("maxframe", 1'b1, 1'b0, 1'b0, 16'h9C31, 5'd16, 8'd255);
    check_frame("maxframe", 32'h9C31, 16, 8415, 255);

    // wrt held high: exactly one SS_n-high cycle between frames
    tb_cpol = 1'b0; tb_cpha = 1'b0;
    cpol = 1'b0; cpha = 1'b0; lsb_first = 1'b0; data_out = 16'h6600; len = 5'd8; half_div = 8'd1;
    frames_base = frames;
    @(posedge clk); #1;
    wrt = 1'b1;
    wait_done("b2b_first", 200);
    chk("b2b_gap_high", 32'(SS_n), 32'd1);
    @(posedge clk); #1;
    chk("b2b_restart", {30'd0, SS_n, busy}, {30'd0, 2'b01});
    wrt = 1'b0;
    wait_done("b2b_second", 200);
    repeat (20) @(posedge clk);
    #1;
    chk("b2b_frames", 32'(frames - frames_base), 32'd2);
    chk("b2b_last_bits", cap, 32'h66);

    // wrt pulses while busy must not queue frames
    frames_base = frames;
    half_div = 8'd2;
    @(posedge clk); #1;
    wrt = 1'b1;
    @(posedge clk); #1;
    wrt = 1'b0;
    repeat (3) begin
      repeat (5) @(posedge clk);
      #1; wrt = 1'b1;
      @(posedge clk); #1; wrt = 1'b0;
    end
    wait_done("ignore_wrt", 200);
    repeat (30) @(posedge clk);
    #1;
    chk("ignore_wrt_frames", 32'(frames - frames_base), 32'd1);
    chk("ignore_wrt_idle", {30'd0, SS_n, busy}, {30'd0, 2'b10});

    // asynchronous reset at SCLK edge 5 of a mode-0 frame
    @(posedge clk); #1;
    wrt = 1'b1;
    @(posedge clk); #1;
    wrt = 1'b0;
    k = 0; prev = SCLK;
    for (int i = 0; i < 100 && k < 5; i++) begin
      @(posedge clk); #1;
      if (SCLK !== prev) k++;
      prev = SCLK;
    end
    chk("rst_edge5_reached", 32'(k), 32'd5);
    chk("rst_pre_state", {28'd0, SCLK, MOSI, SS_n, busy}, {28'd0, 4'b1101});
    done_base = done_cnt;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_outputs", {27'd0, SS_n, SCLK, MOSI, busy, done}, {27'd0, 5'b10000});
    repeat (3) @(posedge clk);
    #1; rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("rst_no_done", 32'(done_cnt - done_base), 32'd0);
    frame("after_rst", 1'b0, 1'b0, 1'b0, 16'h6600, 5'd8, 8'd2);
    check_frame("after_rst", 32'h66, 8, 34, 2);

`ifdef SPI_MSTR_MISO_EN
    frame("miso_msb", 1'b0, 1'b0, 1'b0, 16'hABC0, 5'd12, 8'd2);
    chk("miso_msb_rx", 32'(rx_data), 32'h0ABC);
    frame("miso_lsb", 1'b1, 1'b1, 1'b1, 16'h0ABC, 5'd12, 8'd1);
    chk("miso_lsb_rx", 32'(rx_data), 32'hABC0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/spi_mstr_gen.md
# spi_mstr_gen

Parametrised SPI master, the next generation of the fixed 8/16-bit SPI stimulus master. It adds runtime frame length from 1 to DATA_W bits, all four CPOL/CPHA modes, MSB- or LSB-first order and a programmable SCLK divider. It drives SS_n/SCLK/MOSI into the channel muxes for SPI protocol-trigger testing of LA_dig. It is also usable as a general system SPI master.

## Interface
- DATA_W, 16: maximum frame length and width of data_out.
- DIV_W, 8: width of the SCLK half-period divider.
- LEN_W, $clog2(DATA_W+1): width of len (derived; do not override).
- clk  in  1  system clock (100 MHz domain).
- rst_n  in  1  asynchronous active-low reset.
- wrt  in  1  start request; sampled only in IDLE.
- data_out  in  DATA_W  transmit word.
- len  in  LEN_W  frame length in bits; 0 or >DATA_W treated as DATA_W.
- cpol  in  1  SCLK idle level.
- cpha  in  1  0: sample on leading edge; 1: sample on trailing edge.
- lsb_first  in  1  bit order.
- half_div  in  DIV_W  SCLK half-period in clk cycles; 0 treated as 1.
- SS_n  out  1  active-low select; reset 1.
- SCLK  out  1  serial clock; reset 0.
- MOSI  out  1  serial data; reset 0.
- busy  out  1  high from accept to done; reset 0.
- done  out  1  one-cycle pulse at frame end; reset 0.

All outputs are registered. Clocking is one clock domain, and reset is asynchronous and active-low.

## Operation
- States: IDLE, FRONT, SHIFT, BACK.
- IDLE:
  - SCLK tracks cpol, registered each cycle.
  - When wrt=1, latch data_out, len, cpol, cpha, lsb_first and half_div, then go to FRONT.
  - Inputs may change freely after acceptance.
- Frame bits:
  - MSB-first sends data_out[DATA_W-1 -: L], high bit first.
  - LSB-first sends data_out[0 +: L], bit 0 first.
  - So 16'h6600 with L=8 sends byte 0x66.
- FRONT:
  - SS_n goes low.
  - With cpha=0, MOSI presents bit 0 of the frame.
  - Hold for H = max(half_div, 1) cycles, then go to SHIFT.
- SHIFT:
  - SCLK toggles every H cycles, for exactly 2·L toggles.
  - cpha=0: MOSI advances on each trailing edge except the last.
  - cpha=1: MOSI advances on each leading edge, including the first.
- BACK:
  - SCLK is at cpol, MOSI holds its last bit.
  - Hold H cycles, then SS_n goes high, done pulses, busy drops, and the state returns to IDLE.
- wrt asserted while busy is ignored, not queued. The earliest new accept is the cycle after done.
- Divider counter: counts 0..H-1 and reloads on every edge.
- Edge counter: LEN_W+1 bits and never wraps. The maximum frame (L=DATA_W, half_div=2^DIV_W-1) is legal.
- Reset mid-frame: all outputs return to reset values immediately and the FSM goes to IDLE. No done pulse is issued.

## Timing
- wrt=1 at cycle 0: SS_n is low and busy is high from cycle 1.
- First SCLK edge: cycle 1+H.
- Edge k (1..2L): cycle 1+k·H.
- SS_n rises and done pulses at cycle 1+(2L+1)·H.
- SS_n low time: (2L+1)·H cycles.
- MOSI setup to the sampling edge is at least H cycles in every mode.

## Configuration
- SPI_MSTR_MISO_EN compiles in full-duplex receive.
  - Adds input MISO and output rx_data[DATA_W-1:0] (reset 0).
  - MISO is sampled on each sampling edge and shifted in the frame's bit order.
  - rx_data updates in the done cycle, right-aligned for MSB-first and left-aligned for LSB-first.
- Without the macro, neither port exists and no receive logic is built.

## Structure
- Package spi_pkg holds:
  - the state enum typedef (IDLE, FRONT, SHIFT, BACK);
  - the mode encoding constants MODE0..MODE3 = {cpol, cpha};
  - a function that clamps len and half_div.
- One sub-module, spi_clk_div: the H-cycle divider with a load/terminal-count interface, reused by the logic-analyzer protocol triggers.

## Test plan
- DATA_W=16, len=8, mode 0, MSB-first, half_div=2, data 16'h6600 -> MOSI bits 0,1,1,0,0,1,1,0 sampled on SCLK rising edges; SS_n low 34 cycles; one done pulse.
- Same frame in modes 1, 2 and 3 -> identical sampled bits.
  - Idle SCLK equals cpol.
  - With cpha=1, the first edge carries no data.
- len=0 and len=16, LSB-first, data 16'hA5C3, half_div=0 -> 16 bits, order 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1; SS_n low 33 cycles.
- wrt held high continuously -> back-to-back frames with SS_n high for exactly one cycle between them; wrt pulses while busy produce no extra frames.
- rst_n dropped at edge 5 of a frame -> SS_n=1, SCLK=0, MOSI=0, busy=0 asynchronously; no done; the next wrt starts a clean frame.
- With SPI_MSTR_MISO_EN, MISO looped to MOSI, len=12, data 16'hABC0, MSB-first -> rx_data=16'h0ABC at done.
